// File: rtl/avl_arb_pkg.sv
// avl_arb_pkg: shared state encoding and grant codes for the Avalon-MM two-master arbiter.
package avl_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    localparam logic [1:0] GRANT_M0 = 2'b01;
    localparam logic [1:0] GRANT_M1 = 2'b10;
endpackage

// File: rtl/avl_arb_rr_pick.sv
// avl_arb_rr_pick: combinational 2-way round-robin picker; on a tie the master that did not own last wins.
module avl_arb_rr_pick
    import avl_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);
    always_comb pick = (&req) ? (last ? GRANT_M0 : GRANT_M1) : req;
endmodule

// File: rtl/avl_bus_arbiter.sv
// avl_bus_arbiter: two-master/one-slave Avalon-MM round-robin arbiter holding the grant until transfer completes.
// Define AVL_ARB_PERF_COUNTERS_EN to add transfer and stall counters.
module avl_bus_arbiter
    import avl_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter bit M1_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_waitrequest,
`ifdef AVL_ARB_PERF_COUNTERS_EN
    output logic [31:0]         m0_xfer_count,
    output logic [31:0]         m1_xfer_count,
    output logic [31:0]         stall_count,
`endif
    output logic [1:0]          grant
);
    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       req0, req1, own0, own1;
    logic [1:0] pick;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign own0 = state_q == OWN0;
    assign own1 = state_q == OWN1;

    avl_arb_rr_pick u_pick (
        .req  ({req1, req0}),
        .last (last_q),
        .pick (pick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= ~M1_FIRST;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // A transfer hands straight to the other master when it is waiting, so a switch costs no idle cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: state_d = pick[1] ? OWN1 : pick[0] ? OWN0 : IDLE;
            OWN0: begin
                if (!req0) state_d = IDLE;
                else if (!s_waitrequest) begin
                    last_d  = 1'b0;
                    state_d = req1 ? OWN1 : OWN0;
                end
            end
            OWN1: begin
                if (!req1) state_d = IDLE;
                else if (!s_waitrequest) begin
                    last_d  = 1'b1;
                    state_d = req0 ? OWN0 : OWN1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant          = own0 ? GRANT_M0 : own1 ? GRANT_M1 : 2'b00;
        s_address      = own0 ? m0_address : own1 ? m1_address : '0;
        s_read         = own0 ? m0_read : own1 ? m1_read : 1'b0;
        s_write        = own0 ? m0_write : own1 ? m1_write : 1'b0;
        s_writedata    = own0 ? m0_writedata : own1 ? m1_writedata : '0;
        s_byteenable   = own0 ? m0_byteenable : own1 ? m1_byteenable : '0;
        m0_readdata    = own0 ? s_readdata : '0;
        m1_readdata    = own1 ? s_readdata : '0;
        m0_waitrequest = own0 ? s_waitrequest : 1'b1;
        m1_waitrequest = own1 ? s_waitrequest : 1'b1;
    end

`ifdef AVL_ARB_PERF_COUNTERS_EN
    logic [31:0] m0_xfer_q, m0_xfer_d, m1_xfer_q, m1_xfer_d, stall_q, stall_d;

    always_comb begin
        m0_xfer_d = m0_xfer_q + 32'(own0 & req0 & ~s_waitrequest);
        m1_xfer_d = m1_xfer_q + 32'(own1 & req1 & ~s_waitrequest);
        stall_d   = stall_q + 32'((req0 & m0_waitrequest) | (req1 & m1_waitrequest));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_xfer_q <= '0;
            m1_xfer_q <= '0;
            stall_q   <= '0;
        end else begin
            m0_xfer_q <= m0_xfer_d;
            m1_xfer_q <= m1_xfer_d;
            stall_q   <= stall_d;
        end
    end

    assign m0_xfer_count = m0_xfer_q;
    assign m1_xfer_count = m1_xfer_q;
    assign stall_count   = stall_q;
`endif
endmodule

// File: tb/tb_avl_bus_arbiter.sv
// tb_avl_bus_arbiter: scoreboard bench; a transaction-level arbiter model predicts per-cycle outputs and transfers.
module tb_avl_bus_arbiter;
    typedef struct packed {
        logic [1:0]  grant;
        logic        s_read, s_write;
        logic [31:0] s_address, s_writedata;
        logic [3:0]  s_byteenable;
        logic [31:0] m0_rd, m1_rd;
        logic        m0_w, m1_w;
    } obs_t;
    typedef struct packed {
        logic [1:0]  m;
        logic [31:0] rd;
        logic [31:0] addr;
    } xfer_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] m0_address = '0, m1_address = '0, m0_writedata = '0, m1_writedata = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
    logic        m0_waitrequest, m1_waitrequest, s_read, s_write;
    logic [3:0]  s_byteenable;
    logic [31:0] s_readdata = '0;
    logic        s_waitrequest = 1'b0;
    logic [1:0]  grant;
`ifdef AVL_ARB_PERF_COUNTERS_EN
    logic [31:0] m0_xfer_count, m1_xfer_count, stall_count;
`endif

    avl_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .M1_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
`ifdef AVL_ARB_PERF_COUNTERS_EN
        .m0_xfer_count(m0_xfer_count), .m1_xfer_count(m1_xfer_count), .stall_count(stall_count),
`endif
        .grant(grant)
    );

    always #5 clk = ~clk;

    obs_t dut_o;
    assign dut_o = {grant, s_read, s_write, s_address, s_writedata, s_byteenable,
                    m0_readdata, m1_readdata, m0_waitrequest, m1_waitrequest};

    obs_t        exp_q[$];
    xfer_t       xfer_q[$];
    logic [1:0]  ghist[$];
    int          tests = 0, fails = 0, obs_xfers = 0, cyc_no = 0;
    bit          hist_en = 1'b0;
    // Model: owner 0 = nobody, 1 = M0, 2 = M1; last holds the previous owner.
    int          owner = 0, last = 1;
    int unsigned n_x0 = 0, n_x1 = 0, n_stall = 0;

    function automatic obs_t idle_o();
        obs_t e;
        e = '0;
        e.m0_w = 1'b1;
        e.m1_w = 1'b1;
        return e;
    endfunction

    obs_t  mon_e;
    xfer_t mon_x, mon_g;
    always @(negedge clk) begin
        cyc_no++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            tests++;
            if (dut_o !== mon_e) begin
                fails++;
                $display("FAIL cycle %0d outputs: got %h want %h", cyc_no, dut_o, mon_e);
            end
        end
        if (reset_n && hist_en) ghist.push_back(grant);
        if (reset_n && ((!m0_waitrequest && (m0_read || m0_write)) || (!m1_waitrequest && (m1_read || m1_write)))) begin
            obs_xfers++;
            tests++;
            mon_g.m    = !m0_waitrequest ? 2'd1 : 2'd2;
            mon_g.rd   = !m0_waitrequest ? m0_readdata : m1_readdata;
            mon_g.addr = s_address;
            if (xfer_q.size() == 0) begin
                fails++;
                $display("FAIL xfer cycle %0d: got unexpected transfer %h want none", cyc_no, mon_g);
            end else begin
                mon_x = xfer_q.pop_front();
                if (mon_g !== mon_x) begin
                    fails++;
                    $display("FAIL xfer cycle %0d: got %h want %h", cyc_no, mon_g, mon_x);
                end
            end
        end
    end

    task automatic cyc(input bit r0, w0, r1, w1, input logic [31:0] a0, d0, a1, d1,
                       input logic [3:0] b0, b1, input bit sw, input logic [31:0] srd);
        obs_t  e;
        xfer_t x;
        bit    q0, q1, qn, qo;
        @(posedge clk);
        #1;
        m0_read = r0; m0_write = w0; m0_address = a0; m0_writedata = d0; m0_byteenable = b0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = d1; m1_byteenable = b1;
        s_waitrequest = sw; s_readdata = srd;
        #1;
        q0 = r0 | w0;
        q1 = r1 | w1;
        e = idle_o();
        if (owner == 1) begin
            e.grant = 2'b01; e.s_read = r0; e.s_write = w0; e.s_address = a0;
            e.s_writedata = d0; e.s_byteenable = b0; e.m0_rd = srd; e.m0_w = sw;
        end else if (owner == 2) begin
            e.grant = 2'b10; e.s_read = r1; e.s_write = w1; e.s_address = a1;
            e.s_writedata = d1; e.s_byteenable = b1; e.m1_rd = srd; e.m1_w = sw;
        end
        exp_q.push_back(e);
        if ((q0 && e.m0_w) || (q1 && e.m1_w)) n_stall++;
        if (owner == 0) owner = (q0 && q1) ? 3 - last : q0 ? 1 : q1 ? 2 : 0;
        else begin
            qn = owner == 1 ? q0 : q1;
            qo = owner == 1 ? q1 : q0;
            if (!qn) owner = 0;
            else if (!sw) begin
                x.m = owner[1:0]; x.rd = srd; x.addr = owner == 1 ? a0 : a1;
                xfer_q.push_back(x);
                if (owner == 1) n_x0++; else n_x1++;
                last = owner;
                if (qo) owner = 3 - owner;
            end
        end
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (dut_o !== idle_o()) begin
            fails++;
            $display("FAIL reset outputs: got %h want %h", dut_o, idle_o());
        end
        {m0_read, m0_write, m1_read, m1_write} = '0;
        owner = 0; last = 1; n_x0 = 0; n_x1 = 0; n_stall = 0;
        xfer_q.delete();
        repeat (2) @(posedge clk);
`ifdef AVL_ARB_PERF_COUNTERS_EN
        tests++;
        if ({m0_xfer_count, m1_xfer_count, stall_count} !== 96'd0) begin
            fails++;
            $display("FAIL counters reset: got %0d %0d %0d want 0 0 0", m0_xfer_count, m1_xfer_count, stall_count);
        end
`endif
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic [9:0] gseq;
        int         x0;
        bit         q0, q1, s0, s1;
        do_reset();
        // Single M0 read with three slave wait cycles.
        cyc(1, 0, 0, 0, 32'hBFC00000, 0, 0, 0, 4'hF, 0, 1, 32'h8C020004);
        repeat (3) cyc(1, 0, 0, 0, 32'hBFC00000, 0, 0, 0, 4'hF, 0, 1, 32'h8C020004);
        cyc(1, 0, 0, 0, 32'hBFC00000, 0, 0, 0, 4'hF, 0, 0, 32'h8C020004);
        idle_cyc();
        // Both masters from reset, zero-wait slave: strict alternation starting with M1.
        do_reset();
        x0 = obs_xfers;
        hist_en = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 32'h100 + i, 0, 32'h200 + i, 0, 4'hF, 4'hF, 0, 32'hA0 + i);
        @(negedge clk);
        #1 hist_en = 1'b0;
        gseq = '0;
        foreach (ghist[i]) gseq = {gseq[7:0], ghist[i]};
        tests++;
        if (ghist.size() != 5 || gseq !== 10'b00_10_01_10_01 || obs_xfers - x0 != 4) begin
            fails++;
            $display("FAIL fairness: got grants %b (%0d) xfers %0d want 0010011001 (5) xfers 4", gseq, ghist.size(), obs_xfers - x0);
        end
        // M1 write while M0 waits, then M0 gets the bus.
        idle_cyc();
        cyc(1, 0, 0, 1, 32'h40, 0, 32'h1234, 32'hDEADBEEF, 4'hF, 4'b0011, 0, 32'h55);
        cyc(1, 0, 0, 1, 32'h40, 0, 32'h1234, 32'hDEADBEEF, 4'hF, 4'b0011, 0, 32'h55);
        cyc(1, 0, 0, 0, 32'h40, 0, 0, 0, 4'hF, 0, 0, 32'h66);
        idle_cyc();
        // Reset while M0 owns and the slave stalls.
        cyc(1, 0, 0, 0, 32'h80, 0, 0, 0, 4'hF, 0, 1, 32'h1);
        cyc(1, 0, 0, 0, 32'h80, 0, 0, 0, 4'hF, 0, 1, 32'h1);
        do_reset();
        idle_cyc();
        // Back-to-back M0 reads, M1 idle.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 32'h300 + 4 * i, 0, 0, 0, 4'hF, 0, 0, 32'hC0 + i);
        idle_cyc();
        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            q0 = $urandom_range(0, 3) != 0;
            q1 = $urandom_range(0, 3) != 0;
            s0 = $urandom_range(0, 1) == 1;
            s1 = $urandom_range(0, 1) == 1;
            cyc(q0 && s0, q0 && !s0, q1 && s1, q1 && !s1, $urandom, $urandom, $urandom, $urandom,
                4'($urandom), 4'($urandom), $urandom_range(0, 2) == 0, $urandom);
        end
        idle_cyc();
        @(posedge clk);
        #1;
`ifdef AVL_ARB_PERF_COUNTERS_EN
        tests++;
        if (m0_xfer_count !== n_x0 || m1_xfer_count !== n_x1 || stall_count !== n_stall) begin
            fails++;
            $display("FAIL counters: got %0d %0d %0d want %0d %0d %0d", m0_xfer_count, m1_xfer_count, stall_count, n_x0, n_x1, n_stall);
        end
`endif
        @(negedge clk);
        #1;
        tests++;
        if (xfer_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d transfers %0d cycles pending want 0 0", xfer_q.size(), exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
